// File: rtl/ntt_pkg.sv
// Shared constants, FSM state encoding and stride table for the 128-point
// mixed-radix NTT address sequencer.
package ntt_pkg;

    localparam int N               = 128;
    localparam int ADDR_W          = 7;
    localparam int BEATS_PER_STAGE = 32;
    localparam int NUM_STAGES      = 4;
    localparam int CNT_W           = 5;
    localparam int STAGE_W         = 2;
    localparam int LANES           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index 0 is stage 0: strides 32, 8, 2 for radix-4, 1 for the radix-2 pass.
    localparam logic [NUM_STAGES-1:0][ADDR_W-1:0] STRIDE_TAB = {7'd1, 7'd2, 7'd8, 7'd32};
    localparam logic [NUM_STAGES-1:0][2:0]        STRIDE_LOG = {3'd0, 3'd1, 3'd3, 3'd5};

endpackage

// File: rtl/ntt_stage_addr.sv
// Combinational map from (stage, beat count) to four butterfly lane addresses
// and the twiddle base exponent.
module ntt_stage_addr
    import ntt_pkg::*;
(
    input  logic [CNT_W-1:0]              cnt,
    input  logic [STAGE_W-1:0]            stage,
    output logic [LANES-1:0][ADDR_W-1:0]  addr,
    output logic [ADDR_W-1:0]             twiddle_exp
);

    logic [ADDR_W-1:0] stride;
    logic [2:0]        stride_log;
    logic [ADDR_W-1:0] cnt_ext;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] group;
    logic [ADDR_W-1:0] base;

    // Stride 1 reduces the radix-4 formula to 4*cnt + m with a zero offset,
    // so the radix-2 stage needs no separate path.
    always_comb begin
        stride      = STRIDE_TAB[stage];
        stride_log  = STRIDE_LOG[stage];
        cnt_ext     = {2'b00, cnt};
        offset      = cnt_ext & (stride - 7'd1);
        group       = cnt_ext >> stride_log;
        base        = (group << (stride_log + 3'd2)) + offset;
        twiddle_exp = offset << {stage, 1'b0};
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign addr[gi] = base + ADDR_W'(gi) * stride;
        end
    endgenerate

endmodule

// File: rtl/ntt_address_generator.sv
// Address sequencer for the 128-point mixed-radix NTT: FSM, beat counters and
// registered beat outputs. Optional inverse ordering under NTT_INTT_EN.
module ntt_address_generator
    import ntt_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ready,
`ifdef NTT_INTT_EN
    input  logic              inverse,
`endif
    output logic [ADDR_W-1:0] addr_0,
    output logic [ADDR_W-1:0] addr_1,
    output logic [ADDR_W-1:0] addr_2,
    output logic [ADDR_W-1:0] addr_3,
    output logic [6:0]        twiddle_exp,
    output logic [1:0]        stage,
    output logic              addr_valid,
    output logic              stage_last,
    output logic              busy,
    output logic              done
);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [STAGE_W-1:0]              stage_q, stage_d;
    logic                            inv_q, inv_d;
    logic [LANES-1:0][ADDR_W-1:0]    addr_q, addr_d;
    logic [6:0]                      twid_q, twid_d;
    logic                            valid_q, valid_d;
    logic                            last_q, last_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic                            inv_start;
    logic                            load;
    logic [LANES-1:0][ADDR_W-1:0]    gen_addr;
    logic [6:0]                      gen_twid;

`ifdef NTT_INTT_EN
    assign inv_start = inverse;
`else
    assign inv_start = 1'b0;
`endif

    // Fed with the next-beat indices so the output registers hold the beat
    // that cnt_q/stage_q describe.
    ntt_stage_addr u_stage_addr (
        .cnt         (cnt_d),
        .stage       (stage_d),
        .addr        (gen_addr),
        .twiddle_exp (gen_twid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        valid_d = valid_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Leaving DONE and accepting a fresh start share the same edge.
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    inv_d   = inv_start;
                    stage_d = inv_start ? 2'd3 : 2'd0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (valid_q && ready) begin
                    load = 1'b1;
                    if (cnt_q == CNT_W'(BEATS_PER_STAGE - 1)) begin
                        cnt_d   = '0;
                        stage_d = inv_q ? stage_q - 2'd1 : stage_q + 2'd1;
                        if (stage_q == (inv_q ? 2'd0 : 2'd3)) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        addr_d = load ? gen_addr : addr_q;
        twid_d = load ? gen_twid : twid_q;
        last_d = valid_d && (cnt_d == CNT_W'(BEATS_PER_STAGE - 1));
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
            twid_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
            twid_q  <= twid_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_0      = addr_q[0];
    assign addr_1      = addr_q[1];
    assign addr_2      = addr_q[2];
    assign addr_3      = addr_q[3];
    assign twiddle_exp = twid_q;
    assign stage       = stage_q;
    assign addr_valid  = valid_q;
    assign stage_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
